// File: rtl/tron_arena_arbiter.sv
// tron_arena_arbiter: N-player collision arbiter for the light-cycle arena.
// It owns the trail map (one owner ID per cell) and resolves each game step:
// it checks every live head for wall, trail and head-on hits, then writes
// the surviving heads into the map. It also tracks alive/game-over/winner
// state and serves a registered read port for the video colorizer.
module tron_arena_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int COORD_W     = 8,
    parameter int ARENA_COLS  = 160,
    parameter int ARENA_ROWS  = 120,
    parameter int ID_W        = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           step_valid,
    output logic                           step_ready,
    input  logic [NUM_PLAYERS*COORD_W-1:0] loc_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] loc_y,
    output logic                           step_done,
    output logic [NUM_PLAYERS-1:0]         crash_mask,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic                           game_over,
    output logic [ID_W-1:0]                winner,
    input  logic                           clear_req,
    output logic                           busy,
    input  logic [COORD_W-1:0]             pix_col,
    input  logic [COORD_W-1:0]             pix_row,
    output logic [ID_W-1:0]                pix_owner
);

    localparam int NP     = NUM_PLAYERS;
    localparam int DEPTH  = ARENA_COLS * ARENA_ROWS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PIDX_W = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [31:0]       COLS_U    = 32'(ARENA_COLS);
    localparam logic [31:0]       ROWS_U    = 32'(ARENA_ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [PIDX_W-1:0] LAST_P    = PIDX_W'(NP - 1);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_PAIR  = 3'd2,
        S_RD    = 3'd3,
        S_CHK   = 3'd4,
        S_WR    = 3'd5,
        S_FIN   = 3'd6
    } state_e;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    function automatic logic in_bounds(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        return (32'(x) < COLS_U) && (32'(y) < ROWS_U);
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(ARENA_COLS) + ADDR_W'(x);
    endfunction

    function automatic logic [ID_W-1:0] count_ones(input logic [NP-1:0] m);
        logic [ID_W-1:0] c;
        c = '0;
        for (int i = 0; i < NP; i++) begin
            c = c + ID_W'(m[i]);
        end
        return c;
    endfunction

    // ID (index+1) of the only set bit, or 0 when zero or several are set.
    function automatic logic [ID_W-1:0] sole_id(input logic [NP-1:0] m);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            r = m[i] ? ID_W'(i + 1) : r;
        end
        return (count_ones(m) == ID_W'(1)) ? r : '0;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e                    state_q, state_d;
    logic [PIDX_W-1:0]         p_q, p_d;
    logic [NP*COORD_W-1:0]     lx_q, lx_d;
    logic [NP*COORD_W-1:0]     ly_q, ly_d;
    logic [NP-1:0]             headon_q, headon_d;
    logic [NP-1:0]             oob_q, oob_d;
    logic [NP-1:0]             crash_acc_q, crash_acc_d;
    logic [ADDR_W-1:0]         clr_addr_q, clr_addr_d;
    logic                      step_done_q, step_done_d;
    logic [NP-1:0]             crash_mask_q, crash_mask_d;
    logic [NP-1:0]             alive_q, alive_d;
    logic                      game_over_q, game_over_d;
    logic [ID_W-1:0]           winner_q, winner_d;
    logic                      busy_q, busy_d;
    logic [ID_W-1:0]           pix_owner_q;

    // Trail RAM and its port-A control.
    logic [ID_W-1:0]           mem [DEPTH];
    logic [ID_W-1:0]           ram_rdata_q;
    logic                      ram_we_s;
    logic                      ram_re_s;
    logic [ADDR_W-1:0]         ram_addr_s;
    logic [ID_W-1:0]           ram_wdata_s;

    logic [COORD_W-1:0]        cur_x_s;
    logic [COORD_W-1:0]        cur_y_s;
    logic [ADDR_W-1:0]         cur_addr_s;
    logic [NP-1:0]             headon_s;
    logic [NP-1:0]             oob_s;
    logic [NP-1:0]             new_alive_s;
    logic                      pix_ok_s;
    logic [ADDR_W-1:0]         pix_addr_s;
    logic                      step_ready_s;

    assign cur_x_s      = lx_q[int'(p_q)*COORD_W +: COORD_W];
    assign cur_y_s      = ly_q[int'(p_q)*COORD_W +: COORD_W];
    assign cur_addr_s   = cell_addr(cur_x_s, cur_y_s);
    assign new_alive_s  = alive_q & ~crash_acc_q;
    assign pix_ok_s     = in_bounds(pix_col, pix_row);
    assign pix_addr_s   = cell_addr(pix_col, pix_row);
    assign step_ready_s = (state_q == S_IDLE) & ~game_over_q & ~clear_req;

    // Head-on and wall masks from the latched positions; dead players never collide.
    always_comb begin
        headon_s = '0;
        oob_s    = '0;
        for (int p = 0; p < NP; p++) begin
            oob_s[p] = ~in_bounds(lx_q[p*COORD_W +: COORD_W], ly_q[p*COORD_W +: COORD_W]);
            for (int q = 0; q < NP; q++) begin
                headon_s[p] = headon_s[p] |
                    ((q != p) && alive_q[p] && alive_q[q] &&
                     (lx_q[p*COORD_W +: COORD_W] == lx_q[q*COORD_W +: COORD_W]) &&
                     (ly_q[p*COORD_W +: COORD_W] == ly_q[q*COORD_W +: COORD_W]));
            end
        end
    end

    // Next-state and port-A control for the sweep/step sequencer.
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        lx_d         = lx_q;
        ly_d         = ly_q;
        headon_d     = headon_q;
        oob_d        = oob_q;
        crash_acc_d  = crash_acc_q;
        clr_addr_d   = clr_addr_q;
        step_done_d  = 1'b0;
        crash_mask_d = crash_mask_q;
        alive_d      = alive_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        busy_d       = busy_q;
        ram_we_s     = 1'b0;
        ram_re_s     = 1'b0;
        ram_addr_s   = '0;
        ram_wdata_s  = '0;

        case (state_q)
            S_CLEAR: begin
                ram_we_s   = 1'b1;
                ram_addr_s = clr_addr_q;
                if (clr_addr_q == LAST_ADDR) begin
                    clr_addr_d   = '0;
                    alive_d      = '1;
                    game_over_d  = 1'b0;
                    winner_d     = '0;
                    crash_mask_d = '0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    clr_addr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = S_CLEAR;
                end else if (step_valid && step_ready_s) begin
                    lx_d    = loc_x;
                    ly_d    = loc_y;
                    state_d = S_PAIR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PAIR: begin
                headon_d    = headon_s;
                oob_d       = oob_s;
                crash_acc_d = '0;
                p_d         = '0;
                state_d     = S_RD;
            end
            S_RD: begin
                // Dead or off-arena players have no cell worth reading.
                if (alive_q[p_q] && !oob_q[p_q]) begin
                    ram_re_s   = 1'b1;
                    ram_addr_s = cur_addr_s;
                end else begin
                    ram_re_s   = 1'b0;
                end
                state_d = S_CHK;
            end
            S_CHK: begin
                if (alive_q[p_q] && (headon_q[p_q] || oob_q[p_q] || (ram_rdata_q != '0))) begin
                    crash_acc_d[p_q] = 1'b1;
                end else begin
                    crash_acc_d[p_q] = crash_acc_q[p_q];
                end
                state_d = S_WR;
            end
            S_WR: begin
                if (alive_q[p_q] && !crash_acc_q[p_q]) begin
                    ram_we_s    = 1'b1;
                    ram_addr_s  = cur_addr_s;
                    ram_wdata_s = ID_W'(p_q) + ID_W'(1);
                end else begin
                    ram_we_s    = 1'b0;
                end
                if (p_q == LAST_P) begin
                    state_d = S_FIN;
                end else begin
                    p_d     = p_q + PIDX_W'(1);
                    state_d = S_RD;
                end
            end
            S_FIN: begin
                crash_mask_d = crash_acc_q;
                alive_d      = new_alive_s;
                game_over_d  = (count_ones(new_alive_s) <= ID_W'(1));
                winner_d     = sole_id(new_alive_s);
                step_done_d  = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                clr_addr_d = '0;
                busy_d     = 1'b1;
                state_d    = S_CLEAR;
            end
        endcase
    end

    // Sequencer and status registers; reset restarts the arena sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_CLEAR;
            p_q          <= '0;
            lx_q         <= '0;
            ly_q         <= '0;
            headon_q     <= '0;
            oob_q        <= '0;
            crash_acc_q  <= '0;
            clr_addr_q   <= '0;
            step_done_q  <= 1'b0;
            crash_mask_q <= '0;
            alive_q      <= '1;
            game_over_q  <= 1'b0;
            winner_q     <= '0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            lx_q         <= lx_d;
            ly_q         <= ly_d;
            headon_q     <= headon_d;
            oob_q        <= oob_d;
            crash_acc_q  <= crash_acc_d;
            clr_addr_q   <= clr_addr_d;
            step_done_q  <= step_done_d;
            crash_mask_q <= crash_mask_d;
            alive_q      <= alive_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            busy_q       <= busy_d;
        end
    end

    // Trail RAM port A: sequencer write and 1-cycle registered read.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[ram_addr_s] <= ram_wdata_s;
        end
        if (ram_re_s) begin
            ram_rdata_q <= mem[ram_addr_s];
        end
    end

    // Trail RAM port B: registered video read, off-arena cells read as empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_owner_q <= '0;
        end else begin
            pix_owner_q <= pix_ok_s ? mem[pix_addr_s] : '0;
        end
    end

    assign step_ready = step_ready_s;
    assign step_done  = step_done_q;
    assign crash_mask = crash_mask_q;
    assign alive      = alive_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign busy       = busy_q;
    assign pix_owner  = pix_owner_q;

endmodule
